// File: rtl/serial_capture_pkg.sv
// Shared definitions for the serial capture receiver and its rotate-left source.
// Holds the default word width, the bit-counter width helper and the FSM encoding.
// No ports; imported by the interface and the receiver.
package serial_capture_pkg;

  // Default word width, shared with the parallel-load / rotate-left source.
  localparam int DATA_WIDTH_DEFAULT = 8;

  // Width of a counter that must hold 0 .. width-1.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  // FSM encoding, kept as plain constants for compatibility with older blocks.
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

endpackage

// File: rtl/serial_capture_if.sv
// Bundle between a serial source and the serial capture receiver.
// Ports: sin/start flow source->receiver; q/valid/busy/err flow receiver->observer.
// master modport = source/observer side, slave modport = receiver side.
interface serial_capture_if
  import serial_capture_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
);

  logic                  sin;
  logic                  start;
  logic [DATA_WIDTH-1:0] q;
  logic                  valid;
  logic                  busy;
  logic                  err;

  modport master (
    output sin,
    output start,
    input  q,
    input  valid,
    input  busy,
    input  err
  );

  modport slave (
    input  sin,
    input  start,
    output q,
    output valid,
    output busy,
    output err
  );

endinterface

// File: rtl/serial_capture.sv
// Serial-in parallel-out receiver: rebuilds an MSB-first word framed by a start strobe.
// Ports: clk, rst (async active-high), bus (slave): sin, start in; q, valid, busy, err out.
// Word completes on the (DATA_WIDTH-1)th edge after start; valid/err are one-cycle pulses.
module serial_capture
  import serial_capture_pkg::*;
#(
  parameter  int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  localparam int CNT_WIDTH  = cnt_width(DATA_WIDTH)
) (
  input  logic            clk,
  input  logic            rst,
  serial_capture_if.slave bus
);

  localparam logic [CNT_WIDTH-1:0] LAST_BIT = CNT_WIDTH'(DATA_WIDTH - 1);

  logic [0:0]            state;
  logic [DATA_WIDTH-1:0] sreg;
  logic [CNT_WIDTH-1:0]  cnt;
  logic [DATA_WIDTH-1:0] q_r;
  logic                  valid_r;
  logic                  err_r;

  // First bit of a frame lands in the LSB; earlier bits are cleared.
  logic [DATA_WIDTH-1:0] first_bit;
  logic [DATA_WIDTH-1:0] shifted;

  assign first_bit = {{(DATA_WIDTH-1){1'b0}}, bus.sin};
  assign shifted   = {sreg[DATA_WIDTH-2:0], bus.sin};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      sreg    <= '0;
      cnt     <= '0;
      q_r     <= '0;
      valid_r <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      err_r   <= 1'b0;
      case (state)
        ST_IDLE: begin
          // sin is only looked at when a frame is being accepted.
          if (bus.start) begin
            sreg  <= first_bit;
            cnt   <= CNT_WIDTH'(1);
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (bus.start) begin
            // A new strobe mid-frame wins: drop the partial word and restart.
            err_r <= 1'b1;
            sreg  <= first_bit;
            cnt   <= CNT_WIDTH'(1);
          end else if (cnt == LAST_BIT) begin
            sreg    <= shifted;
            q_r     <= shifted;
            valid_r <= 1'b1;
            cnt     <= '0;
            state   <= ST_IDLE;
          end else begin
            sreg <= shifted;
            cnt  <= cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.q     = q_r;
  assign bus.valid = valid_r;
  assign bus.err   = err_r;
  assign bus.busy  = (state == ST_SHIFT);

endmodule

// File: tb/tb_serial_capture.sv
// Testbench for serial_capture: scoreboard of expected words, per-scenario tasks.
// Ports: none; drives the receiver through a serial_capture_if instance.
// Includes a rotate-left load register as a loopback serial source.
module tb_serial_capture;

  localparam int W = 8;

  logic clk;
  logic rst;

  serial_capture_if #(.DATA_WIDTH(W)) bus ();

  serial_capture #(.DATA_WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rotate-left source: load when ld_n is low, otherwise rotate; MSB is the serial bit.
  logic         ld_n;
  logic [W-1:0] ld_val;
  logic [W-1:0] rot;
  logic         use_loop;
  logic         sin_drv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rot <= '0;
    else if (!ld_n) rot <= ld_val;
    else            rot <= {rot[W-2:0], rot[W-1]};
  end

  assign bus.sin = use_loop ? rot[W-1] : sin_drv;

  int checks;
  int errors;
  int vld_seen;
  int err_seen;
  logic [W-1:0] sb[$];

  // One clock: apply inputs, take the edge, sample 1 time unit later.
  // Every valid pulse is matched against the oldest expected word.
  task automatic cyc(input logic s, input logic st);
    logic [W-1:0] exp_q;
    sin_drv   = s;
    bus.start = st;
    @(posedge clk);
    #1;
    if (bus.err === 1'b1) err_seen++;
    if (bus.valid === 1'b1) begin
      vld_seen++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_valid q=%h required no valid", bus.q);
      end else begin
        exp_q = sb.pop_front();
        if (bus.q !== exp_q) begin
          errors++;
          $display("FAIL sb_word q=%h required %h", bus.q, exp_q);
        end
      end
    end
  endtask

  task automatic send_frame(input logic [W-1:0] w, input bit push);
    if (push) sb.push_back(w);
    for (int i = W - 1; i >= 0; i--) cyc(w[i], i == W - 1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) cyc(1'b1, 1'b1);
    checks++;
    if ({bus.q, bus.valid, bus.busy, bus.err} !== {{W{1'b0}}, 3'b000}) begin
      errors++;
      $display("FAIL reset_state q=%h v=%b b=%b e=%b required 0 0 0 0",
               bus.q, bus.valid, bus.busy, bus.err);
    end
    @(negedge clk);
    rst = 1'b0;
    cyc(1'b0, 1'b0);
  endtask

  task automatic test_single();
    logic [W-1:0] w;
    w = 8'hA5;
    vld_seen = 0;
    sb.push_back(w);
    for (int i = W - 1; i >= 0; i--) begin
      cyc(w[i], i == W - 1);
      checks++;
      if (bus.busy !== (i != 0)) begin
        errors++;
        $display("FAIL single_busy bit=%0d busy=%b required %b", i, bus.busy, i != 0);
      end
      if (i != 0 && bus.valid !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL single_early_valid bit=%0d valid=%b required 0", i, bus.valid);
      end
    end
    checks++;
    if (bus.valid !== 1'b1 || bus.q !== 8'hA5) begin
      errors++;
      $display("FAIL single_done valid=%b q=%h required 1 a5", bus.valid, bus.q);
    end
    cyc(1'b1, 1'b0);
    checks++;
    if (bus.valid !== 1'b0 || bus.q !== 8'hA5 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL single_after valid=%b q=%h busy=%b required 0 a5 0",
               bus.valid, bus.q, bus.busy);
    end
    checks++;
    if (vld_seen != 1) begin
      errors++;
      $display("FAIL single_count valid_pulses=%0d required 1", vld_seen);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] w [2];
    w[0] = 8'hA5;
    w[1] = 8'h3C;
    vld_seen = 0;
    for (int f = 0; f < 2; f++) begin
      sb.push_back(w[f]);
      for (int i = W - 1; i >= 0; i--) begin
        cyc(w[f][i], i == W - 1);
        checks++;
        if (bus.busy !== (i != 0)) begin
          errors++;
          $display("FAIL b2b_busy frame=%0d bit=%0d busy=%b required %b",
                   f, i, bus.busy, i != 0);
        end
      end
      checks++;
      if (bus.valid !== 1'b1 || bus.q !== w[f]) begin
        errors++;
        $display("FAIL b2b_word frame=%0d valid=%b q=%h required 1 %h",
                 f, bus.valid, bus.q, w[f]);
      end
    end
    cyc(1'b0, 1'b0);
    checks++;
    if (vld_seen != 2) begin
      errors++;
      $display("FAIL b2b_count valid_pulses=%0d required 2", vld_seen);
    end
  endtask

  task automatic test_abort();
    vld_seen = 0;
    err_seen = 0;
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    sb.push_back(8'h81);
    cyc(1'b1, 1'b1);
    checks++;
    if (bus.err !== 1'b1 || bus.valid !== 1'b0 || bus.q !== 8'h3C || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_edge err=%b valid=%b q=%h busy=%b required 1 0 3c 1",
               bus.err, bus.valid, bus.q, bus.busy);
    end
    for (int i = W - 2; i >= 0; i--) begin
      logic [W-1:0] v;
      v = 8'h81;
      cyc(v[i], 1'b0);
      if (i == W - 2) begin
        checks++;
        if (bus.err !== 1'b0) begin
          errors++;
          $display("FAIL abort_err_pulse err=%b required 0", bus.err);
        end
      end
    end
    checks++;
    if (bus.valid !== 1'b1 || bus.q !== 8'h81) begin
      errors++;
      $display("FAIL abort_word valid=%b q=%h required 1 81", bus.valid, bus.q);
    end
    cyc(1'b0, 1'b0);
    checks++;
    if (vld_seen != 1 || err_seen != 1) begin
      errors++;
      $display("FAIL abort_counts valid=%0d err=%0d required 1 1", vld_seen, err_seen);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [W-1:0] w;
    send_frame(8'h5A, 1'b1);
    checks++;
    if (bus.q !== 8'h5A) begin
      errors++;
      $display("FAIL rstmid_prior q=%h required 5a", bus.q);
    end
    w = 8'hC3;
    for (int i = W - 1; i >= W - 5; i--) cyc(w[i], i == W - 1);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.q !== 8'h00 || bus.busy !== 1'b0 || bus.valid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async q=%h busy=%b valid=%b required 00 0 0",
               bus.q, bus.busy, bus.valid);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    send_frame(8'h0F, 1'b1);
    checks++;
    if (bus.q !== 8'h0F || bus.valid !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_fresh q=%h valid=%b required 0f 1", bus.q, bus.valid);
    end
    cyc(1'b0, 1'b0);
  endtask

  task automatic test_idle_noise();
    for (int i = 0; i < 20; i++) begin
      cyc(i[0], 1'b0);
      checks++;
      if (bus.q !== 8'h0F || bus.valid !== 1'b0 || bus.busy !== 1'b0 || bus.err !== 1'b0) begin
        errors++;
        $display("FAIL idle_noise cycle=%0d q=%h v=%b b=%b e=%b required 0f 0 0 0",
                 i, bus.q, bus.valid, bus.busy, bus.err);
      end
    end
  endtask

  task automatic test_loopback();
    logic [W-1:0] words [3];
    words[0] = 8'h81;
    words[1] = 8'h00;
    words[2] = 8'hFF;
    use_loop = 1'b1;
    for (int n = 0; n < 3; n++) begin
      vld_seen = 0;
      ld_val = words[n];
      ld_n = 1'b0;
      cyc(1'b0, 1'b0);
      ld_n = 1'b1;
      sb.push_back(words[n]);
      for (int k = 0; k < W; k++) cyc(1'b0, k == 0);
      checks++;
      if (bus.valid !== 1'b1 || bus.q !== words[n]) begin
        errors++;
        $display("FAIL loop_word n=%0d valid=%b q=%h required 1 %h",
                 n, bus.valid, bus.q, words[n]);
      end
      cyc(1'b0, 1'b0);
      checks++;
      if (vld_seen != 1) begin
        errors++;
        $display("FAIL loop_count n=%0d valid_pulses=%0d required 1", n, vld_seen);
      end
    end
    use_loop = 1'b0;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    vld_seen  = 0;
    err_seen  = 0;
    rst       = 1'b1;
    ld_n      = 1'b1;
    ld_val    = '0;
    use_loop  = 1'b0;
    sin_drv   = 1'b0;
    bus.start = 1'b0;

    test_reset();
    test_single();
    test_back_to_back();
    test_abort();
    test_reset_mid_frame();
    test_idle_noise();
    test_loopback();

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover pending=%0d required 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
